// File: rtl/siphash_msg_ctrl_pkg.sv
// Shared definitions for the SipHash message sequencer: widths, FSM states, last-block byte masks.
// Optional cycle counter is enabled with SIPHASH_MSG_CTRL_PERF_EN (see siphash_msg_ctrl).
package siphash_msg_ctrl_pkg;

    localparam int unsigned WORD_W     = 64;
    localparam int unsigned KEY_W      = 128;
    localparam int unsigned LEN_W      = 8;
    localparam int unsigned BYTES_W    = 4;
    localparam int unsigned ROUNDS_W   = 4;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned FULL_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_WORD  = 3'd2,
        ST_CWAIT = 3'd3,
        ST_PAD   = 3'd4,
        ST_FIN   = 3'd5,
        ST_FWAIT = 3'd6
    } state_t;

    // Keep-mask for the low n bytes of a final block; n >= 8 keeps the whole word.
    function automatic logic [WORD_W-1:0] byte_mask(input logic [BYTES_W-1:0] n);
        logic [WORD_W-1:0] m;
        case (n)
            4'd0:    m = 64'h0000_0000_0000_0000;
            4'd1:    m = 64'h0000_0000_0000_00ff;
            4'd2:    m = 64'h0000_0000_0000_ffff;
            4'd3:    m = 64'h0000_0000_00ff_ffff;
            4'd4:    m = 64'h0000_0000_ffff_ffff;
            4'd5:    m = 64'h0000_00ff_ffff_ffff;
            4'd6:    m = 64'h0000_ffff_ffff_ffff;
            4'd7:    m = 64'h00ff_ffff_ffff_ffff;
            default: m = '1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/siphash_msg_ctrl_pad.sv
// Final-block padding: keeps the valid low bytes and places the message length in byte 7.
// Full words (in_bytes >= 8) pass through untouched; their length block is issued separately.
module siphash_pad
    import siphash_msg_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0]  in_data,
    input  logic [BYTES_W-1:0] in_bytes,
    input  logic [LEN_W-1:0]   len,
    output logic [WORD_W-1:0]  block_c
);

    always_comb begin
        block_c = in_data;
        if (in_bytes < BYTES_W'(FULL_BYTES)) begin
            block_c                    = in_data & byte_mask(in_bytes);
            block_c[WORD_W-1 -: LEN_W] = len;
        end
    end

endmodule

// File: rtl/siphash_msg_ctrl.sv
// Message-level sequencer for siphash_core: pads, issues init/compress/finalize, folds the digest.
// Define SIPHASH_MSG_CTRL_PERF_EN to add the saturating busy-cycle counter output cycle_count.
module siphash_msg_ctrl
    import siphash_msg_ctrl_pkg::*;
#(
    parameter int unsigned COMP_ROUNDS  = 2,
    parameter int unsigned FINAL_ROUNDS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [KEY_W-1:0]      key,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_W-1:0]     in_data,
    input  logic                  in_last,
    input  logic [BYTES_W-1:0]    in_bytes,
    output logic                  busy,
    output logic [WORD_W-1:0]     digest,
    output logic                  digest_valid,
    output logic                  core_initalize,
    output logic                  core_compress,
    output logic                  core_finalize,
    output logic                  core_long,
    output logic [KEY_W-1:0]      core_key,
    output logic [WORD_W-1:0]     core_mi,
    output logic [ROUNDS_W-1:0]   core_compression_rounds,
    output logic [ROUNDS_W-1:0]   core_final_rounds,
    input  logic                  core_ready,
    input  logic [2*WORD_W-1:0]   core_word,
    input  logic                  core_word_valid
`ifdef SIPHASH_MSG_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      cycle_count
`endif
);

    state_t state, state_next;
    state_t ret_state, ret_next;
    logic   first_wait, first_next;

    logic [KEY_W-1:0]   key_reg, key_d;
    logic [LEN_W-1:0]   len_reg, len_d;
    logic [WORD_W-1:0]  mi_reg, mi_d;
    logic [WORD_W-1:0]  digest_d;
    logic               digest_valid_d, busy_d, in_ready_d;
    logic               init_d, comp_d, fin_d;

    logic               start_c, hs_c, capture_c, cwait_done_c;
    logic [BYTES_W-1:0] eff_bytes_c;
    logic [LEN_W-1:0]   len_next_c;
    logic [WORD_W-1:0]  pad_block_c;

    assign start_c      = (state == ST_IDLE) && start;
    assign hs_c         = (state == ST_WORD) && in_valid && in_ready;
    assign cwait_done_c = (state == ST_CWAIT) && !first_wait && core_ready;
    assign capture_c    = (state == ST_FWAIT) && !first_wait && core_ready && core_word_valid;

    // Bytes contributed by the current word: 8 unless it is a short last word.
    assign eff_bytes_c = (in_last && (in_bytes < BYTES_W'(FULL_BYTES))) ? in_bytes
                                                                        : BYTES_W'(FULL_BYTES);
    assign len_next_c  = len_reg + LEN_W'(eff_bytes_c);

    siphash_pad u_pad (
        .in_data  (in_data),
        .in_bytes (in_bytes),
        .len      (len_next_c),
        .block_c  (pad_block_c)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ret_state  <= ST_IDLE;
            first_wait <= 1'b0;
        end else begin
            state      <= state_next;
            ret_state  <= ret_next;
            first_wait <= first_next;
        end
    end

    // first_wait marks the strobe cycle of a wait state, before the core has seen the command.
    always_comb begin
        state_next = state;
        ret_next   = ret_state;
        first_next = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_next = ST_INIT;
            ST_INIT:  state_next = ST_WORD;
            ST_WORD: begin
                if (hs_c) begin
                    state_next = ST_CWAIT;
                    first_next = 1'b1;
                    if (!in_last)
                        ret_next = ST_WORD;
                    else if (in_bytes >= BYTES_W'(FULL_BYTES))
                        ret_next = ST_PAD;
                    else
                        ret_next = ST_FIN;
                end
            end
            ST_CWAIT: if (cwait_done_c) state_next = ret_state;
            ST_PAD: begin
                state_next = ST_CWAIT;
                ret_next   = ST_FIN;
                first_next = 1'b1;
            end
            ST_FIN: begin
                state_next = ST_FWAIT;
                first_next = 1'b1;
            end
            ST_FWAIT: if (capture_c) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_d     = (state_next == ST_WORD);
        busy_d         = (state_next != ST_IDLE);
        init_d         = (state == ST_INIT);
        comp_d         = hs_c || (state == ST_PAD);
        fin_d          = (state == ST_FIN);
        key_d          = key_reg;
        len_d          = len_reg;
        mi_d           = mi_reg;
        digest_d       = digest;
        digest_valid_d = digest_valid;
        if (start_c) begin
            key_d          = key;
            len_d          = '0;
            digest_valid_d = 1'b0;
        end
        if (hs_c) begin
            len_d = len_next_c;
            mi_d  = in_last ? pad_block_c : in_data;
        end
        if (state == ST_PAD)
            mi_d = {len_reg, (WORD_W-LEN_W)'(0)};
        if (capture_c) begin
            digest_d       = core_word[2*WORD_W-1:WORD_W] ^ core_word[WORD_W-1:0];
            digest_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            core_initalize <= 1'b0;
            core_compress  <= 1'b0;
            core_finalize  <= 1'b0;
            key_reg        <= '0;
            len_reg        <= '0;
            mi_reg         <= '0;
            digest         <= '0;
            digest_valid   <= 1'b0;
        end else begin
            in_ready       <= in_ready_d;
            busy           <= busy_d;
            core_initalize <= init_d;
            core_compress  <= comp_d;
            core_finalize  <= fin_d;
            key_reg        <= key_d;
            len_reg        <= len_d;
            mi_reg         <= mi_d;
            digest         <= digest_d;
            digest_valid   <= digest_valid_d;
        end
    end

    assign core_key                = key_reg;
    assign core_mi                 = mi_reg;
    assign core_long               = 1'b0;
    assign core_compression_rounds = ROUNDS_W'(COMP_ROUNDS);
    assign core_final_rounds       = ROUNDS_W'(FINAL_ROUNDS);

`ifdef SIPHASH_MSG_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            cycle_count <= '0;
        else if (start_c)
            cycle_count <= '0;
        else if (busy && (cycle_count != '1))
            cycle_count <= cycle_count + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_siphash_msg_ctrl.sv
// Bench for siphash_msg_ctrl: behavioural SipHash core responder, byte-level reference model,
// scoreboard queues for message blocks and digests checked by an independent monitor.
module tb_siphash_msg_ctrl;

    localparam int unsigned COMP  = 2;
    localparam int unsigned FINR  = 4;
    localparam logic [127:0] KV   = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100};

    logic         clk = 1'b0;
    logic         reset_n, start, in_valid, in_ready, in_last, busy, digest_valid;
    logic [127:0] key, core_key, core_word;
    logic [63:0]  in_data, digest, core_mi;
    logic [3:0]   in_bytes, core_compression_rounds, core_final_rounds;
    logic         core_initalize, core_compress, core_finalize, core_long;
    logic         core_ready, core_word_valid;
`ifdef SIPHASH_MSG_CTRL_PERF_EN
    logic [31:0]  cycle_count;
    int           busy_cycles = 0;
`endif

    int           n_cmp = 0, n_err = 0, comp_total = 0;
    logic [63:0]  exp_mi[$];
    logic [63:0]  exp_dig[$];
    logic [63:0]  last_mi = '0;
    logic         prev_dv = 1'b0, prev_busy = 1'b0;

    always #5 clk = ~clk;

    siphash_msg_ctrl #(.COMP_ROUNDS(COMP), .FINAL_ROUNDS(FINR)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key(key),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_bytes(in_bytes), .busy(busy),
        .digest(digest), .digest_valid(digest_valid),
        .core_initalize(core_initalize), .core_compress(core_compress),
        .core_finalize(core_finalize), .core_long(core_long),
        .core_key(core_key), .core_mi(core_mi),
        .core_compression_rounds(core_compression_rounds),
        .core_final_rounds(core_final_rounds),
        .core_ready(core_ready), .core_word(core_word),
        .core_word_valid(core_word_valid)
`ifdef SIPHASH_MSG_CTRL_PERF_EN
        , .cycle_count(cycle_count)
`endif
    );

    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [255:0] sip_rounds(input logic [255:0] s, input int unsigned n);
        logic [63:0] v0, v1, v2, v3;
        {v0, v1, v2, v3} = s;
        for (int r = 0; r < int'(n); r++) begin
            v0 += v1; v1 = rotl(v1, 13); v1 ^= v0; v0 = rotl(v0, 32);
            v2 += v3; v3 = rotl(v3, 16); v3 ^= v2;
            v0 += v3; v3 = rotl(v3, 21); v3 ^= v0;
            v2 += v1; v1 = rotl(v1, 17); v1 ^= v2; v2 = rotl(v2, 32);
        end
        return {v0, v1, v2, v3};
    endfunction

    function automatic logic [255:0] sip_init(input logic [127:0] k);
        return {k[63:0] ^ 64'h736f6d6570736575, k[127:64] ^ 64'h646f72616e646f6d,
                k[63:0] ^ 64'h6c7967656e657261, k[127:64] ^ 64'h7465646279746573};
    endfunction

    function automatic logic [255:0] sip_compress(input logic [255:0] s, input logic [63:0] m,
                                                  input int unsigned c);
        logic [255:0] t;
        t = s;
        t[63:0] ^= m;
        t = sip_rounds(t, c);
        t[255:192] ^= m;
        return t;
    endfunction

    // SipHash block b of a byte string; the last block carries len mod 256 in byte 7.
    function automatic logic [63:0] ref_block(input byte unsigned m[$], input int b);
        logic [63:0] r;
        int len;
        r   = '0;
        len = m.size();
        for (int j = 0; j < 8; j++)
            if (8*b + j < len) r[8*j +: 8] = m[8*b + j];
        if (b == len/8) r[63:56] = 8'(len);
        return r;
    endfunction

    function automatic logic [63:0] ref_digest(input logic [127:0] k, input byte unsigned m[$]);
        logic [255:0] s;
        s = sip_init(k);
        for (int b = 0; b <= m.size()/8; b++) s = sip_compress(s, ref_block(m, b), COMP);
        s[127:64] ^= 64'hff;
        s = sip_rounds(s, FINR);
        return s[255:192] ^ s[191:128] ^ s[127:64] ^ s[63:0];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    // Behavioural core: init is immediate, compress/finalize hold core_ready low for rounds+3 cycles.
    initial begin : core_model
        logic [255:0] vs;
        int           cnt;
        logic         fin_pending;
        vs = '0; cnt = 0; fin_pending = 1'b0;
        core_ready <= 1'b1; core_word_valid <= 1'b0; core_word <= '0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                vs = '0; cnt = 0; fin_pending = 1'b0;
                core_ready <= 1'b1; core_word_valid <= 1'b0; core_word <= '0;
            end else if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_ready <= 1'b1;
                    if (fin_pending) begin
                        core_word_valid <= 1'b1;
                        fin_pending = 1'b0;
                    end
                end
            end else if (core_initalize) begin
                vs = sip_init(core_key);
                core_word_valid <= 1'b0;
            end else if (core_compress) begin
                vs = sip_compress(vs, core_mi, int'(core_compression_rounds));
                cnt = int'(core_compression_rounds) + 3;
                core_ready <= 1'b0;
            end else if (core_finalize) begin
                vs[127:64] ^= 64'hff;
                vs = sip_rounds(vs, int'(core_final_rounds));
                core_word <= {vs[255:192] ^ vs[191:128], vs[127:64] ^ vs[63:0]};
                cnt = int'(core_final_rounds) + 3;
                fin_pending = 1'b1;
                core_ready <= 1'b0;
                core_word_valid <= 1'b0;
            end
        end
    end

    // Monitor: strobe legality, message blocks and digests against the scoreboard queues.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (core_initalize || core_compress || core_finalize) begin
                    chk("strobe_core_ready", 128'(core_ready), 128'(1));
                    chk("strobe_onehot", 128'(32'(core_initalize) + 32'(core_compress) +
                                              32'(core_finalize)), 128'(1));
                end
                if (core_compress) begin
                    comp_total++;
                    last_mi = core_mi;
                    if (exp_mi.size() == 0) fail_now("mi_extra_compress");
                    else chk("core_mi", 128'(core_mi), 128'(exp_mi.pop_front()));
                end
`ifdef SIPHASH_MSG_CTRL_PERF_EN
                if (busy) busy_cycles = prev_busy ? busy_cycles + 1 : 1;
`endif
                if (digest_valid && !prev_dv) begin
                    if (exp_dig.size() == 0) fail_now("digest_unexpected");
                    else chk("digest", 128'(digest), 128'(exp_dig.pop_front()));
                    chk("mi_remaining", 128'(exp_mi.size()), 128'(0));
                    chk("busy_at_done", 128'(busy), 128'(0));
`ifdef SIPHASH_MSG_CTRL_PERF_EN
                    chk("cycle_count", 128'(cycle_count), 128'(busy_cycles));
`endif
                end
            end
            prev_dv   = digest_valid;
            prev_busy = busy;
        end
    end

    task automatic send_msg(input logic [127:0] k, input byte unsigned m[$], input logic use_const,
                            input logic [63:0] cdig, input logic rnd);
        int          len, nw, w, budget, nb;
        logic [63:0] d;
        logic        lst;
        len = m.size();
        nw  = (len == 0) ? 1 : (len + 7) / 8;
        for (int b = 0; b <= len/8; b++) exp_mi.push_back(ref_block(m, b));
        exp_dig.push_back(use_const ? cdig : ref_digest(k, m));
        @(negedge clk); key = k; start = 1'b1;
        @(negedge clk); start = 1'b0;
        w = 0; budget = 0;
        while (w < nw && budget < 5000) begin
            @(negedge clk);
            lst = (w == nw - 1);
            d   = {$urandom, $urandom};
            for (int j = 0; j < 8; j++)
                if (8*w + j < len) d[8*j +: 8] = m[8*w + j];
            if (!lst)                          nb = $urandom_range(0, 15);
            else if (len - 8*w == 8 && rnd)    nb = $urandom_range(8, 15);
            else                               nb = len - 8*w;
            if (in_ready) begin
                in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data  = d; in_last = lst; in_bytes = 4'(nb);
                if (in_valid) w++;
            end else begin
                in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                in_data  = {$urandom, $urandom}; in_last = 1'($urandom_range(0, 1));
                in_bytes = 4'($urandom_range(0, 15));
            end
            start = rnd && busy && ($urandom_range(0, 7) == 0);
            if (start) key = {$urandom, $urandom, $urandom, $urandom};
            budget++;
        end
        if (w < nw) fail_now("word_accept");
        @(negedge clk); in_valid = 1'b0; start = 1'b0;
        budget = 0;
        while (!digest_valid && budget < 3000) begin
            @(negedge clk); budget++;
        end
        if (!digest_valid) fail_now("digest_valid");
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"},     128'(in_ready), 128'(0));
        chk({tag, "_busy"},         128'(busy), 128'(0));
        chk({tag, "_digest"},       128'(digest), 128'(0));
        chk({tag, "_digest_valid"}, 128'(digest_valid), 128'(0));
        chk({tag, "_strobes"},      128'({core_initalize, core_compress, core_finalize, core_long}), 128'(0));
        chk({tag, "_core_key"},     core_key, 128'(0));
        chk({tag, "_core_mi"},      128'(core_mi), 128'(0));
`ifdef SIPHASH_MSG_CTRL_PERF_EN
        chk({tag, "_cycle_count"},  128'(cycle_count), 128'(0));
`endif
    endtask

    initial begin : stimulus
        byte unsigned msg[$];
        int           c0, cyc;
        reset_n = 1'b0; start = 1'b0; key = '0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; in_bytes = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        chk("comp_rounds",  128'(core_compression_rounds), 128'(2));
        chk("final_rounds", 128'(core_final_rounds), 128'(4));
        @(negedge clk); reset_n = 1'b1;

        // Reference vectors, key 00..0f, message 00..n-1
        msg.delete(); c0 = comp_total;
        send_msg(KV, msg, 1'b1, 64'h726fdb47dd0e0e31, 1'b0);
        chk("empty_compresses", 128'(comp_total - c0), 128'(1));
        chk("empty_mi", 128'(last_mi), 128'(0));

        for (int i = 0; i < 8; i++) msg.push_back(8'(i));
        c0 = comp_total;
        send_msg(KV, msg, 1'b1, 64'h93f5f5799a932462, 1'b0);
        chk("len8_compresses", 128'(comp_total - c0), 128'(2));
        chk("len8_pad_mi", 128'(last_mi), 128'(64'h0800000000000000));

        for (int i = 8; i < 15; i++) msg.push_back(8'(i));
        c0 = comp_total;
        send_msg(KV, msg, 1'b1, 64'ha129ca6149be45e5, 1'b1);
        chk("len15_compresses", 128'(comp_total - c0), 128'(2));
        chk("len15_last_mi", 128'(last_mi), 128'(64'h0f0e0d0c0b0a0908));

        // Random keys, lengths and backpressure
        for (int t = 0; t < 12; t++) begin
            msg.delete();
            for (int i = 0; i < int'($urandom_range(0, 40)); i++) msg.push_back(8'($urandom));
            send_msg({$urandom, $urandom, $urandom, $urandom}, msg, 1'b0, '0, 1'b1);
        end

        // Reset while waiting on the first compress of a 3-word message
        msg.delete();
        for (int i = 0; i < 24; i++) msg.push_back(8'($urandom));
        exp_mi.push_back(ref_block(msg, 0));
        @(negedge clk); key = KV; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
        if (!in_ready) fail_now("abort_in_ready");
        in_valid = 1'b1; in_data = ref_block(msg, 0); in_last = 1'b0; in_bytes = 4'd8;
        @(negedge clk); in_valid = 1'b0;
        cyc = 0;
        while (core_ready && cyc < 20) begin @(negedge clk); cyc++; end
        if (core_ready) fail_now("abort_cwait");
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        exp_mi.delete(); exp_dig.delete();
        @(negedge clk); reset_n = 1'b1;
        msg.delete();
        send_msg(KV, msg, 1'b1, 64'h726fdb47dd0e0e31, 1'b0);

        // 320-byte message: length byte wraps to 64
        msg.delete();
        for (int i = 0; i < 320; i++) msg.push_back(8'($urandom));
        c0 = comp_total;
        send_msg(KV, msg, 1'b0, '0, 1'b1);
        chk("len320_compresses", 128'(comp_total - c0), 128'(41));
        chk("len320_pad_mi", 128'(last_mi), 128'(64'h4000000000000000));

        repeat (5) @(negedge clk);
        chk("digest_hold_valid", 128'(digest_valid), 128'(1));
        chk("scoreboard_empty", 128'(exp_dig.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
